// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: round-robin burst arbiter sharing one UART transmitter between N_REQ byte sources.
module uart_tx_arbiter #(
  parameter int N_REQ        = 4,
  parameter int MAX_BURST    = 8,
  parameter int IDLE_TIMEOUT = 16,
  parameter int GNT_W        = $clog2(N_REQ)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [N_REQ-1:0]     req_valid_i,
  input  logic [N_REQ-1:0]     req_last_i,
  input  logic [8*N_REQ-1:0]   req_data_i,
  output logic [N_REQ-1:0]     req_ready_o,
  input  logic                 tx_busy_i,
  input  logic                 tx_done_i,
  output logic                 tx_start_o,
  output logic [7:0]           tx_data_o,
  output logic                 grant_valid_o,
  output logic [GNT_W-1:0]     grant_id_o
);
  localparam int BW = $clog2(MAX_BURST + 1);
  localparam int IW = $clog2(IDLE_TIMEOUT + 1);
  typedef enum logic [1:0] {IDLE, SEND, LOAD, WAIT} state_e;
  state_e state_q, state_d;
  logic [GNT_W-1:0] rr_q, rr_d, gid_q, gid_d, off, win, nxt;
  logic [GNT_W:0] sum;
  logic [2*N_REQ-1:0] rot;
  logic [BW-1:0] burst_q, burst_d;
  logic [IW-1:0] idle_q, idle_d;
  logic [7:0] data_q, data_d;
  logic last_q, last_d;
  // rot[i] is requester (rr_q + i) mod N_REQ, so the lowest set bit is the winner offset
  always_comb begin
    rot = {req_valid_i, req_valid_i} >> rr_q;
    off = '0;
    for (int i = N_REQ - 1; i >= 0; i--)
      if (rot[i]) off = GNT_W'(i);
    sum = {1'b0, rr_q} + {1'b0, off};
    win = sum >= (GNT_W+1)'(N_REQ) ? GNT_W'(sum - (GNT_W+1)'(N_REQ)) : GNT_W'(sum);
    nxt = gid_q == GNT_W'(N_REQ - 1) ? '0 : gid_q + GNT_W'(1);
  end
  always_comb begin
    state_d = state_q;
    rr_d    = rr_q;
    gid_d   = gid_q;
    burst_d = burst_q;
    idle_d  = idle_q;
    data_d  = data_q;
    last_d  = last_q;
    case (state_q)
      IDLE: if (|req_valid_i) begin
        state_d = SEND;
        gid_d   = win;
        burst_d = '0;
        idle_d  = '0;
      end
      SEND: if (!tx_busy_i && req_valid_i[gid_q]) begin
        data_d  = req_data_i[8*gid_q +: 8];
        last_d  = req_last_i[gid_q];
        idle_d  = '0;
        state_d = LOAD;
      end else if (!req_valid_i[gid_q]) begin
        idle_d = idle_q + IW'(1);
        if (idle_q == IW'(IDLE_TIMEOUT - 1)) begin
          state_d = IDLE;
          rr_d    = nxt;
        end
      end
      LOAD: state_d = WAIT;
      WAIT: if (tx_done_i) begin
        burst_d = burst_q + BW'(1);
        state_d = last_q || burst_q == BW'(MAX_BURST - 1) ? IDLE : SEND;
        rr_d    = last_q || burst_q == BW'(MAX_BURST - 1) ? nxt : rr_q;
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state_q <= IDLE;
      rr_q    <= '0;
      gid_q   <= '0;
      burst_q <= '0;
      idle_q  <= '0;
      data_q  <= '0;
      last_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      rr_q    <= rr_d;
      gid_q   <= gid_d;
      burst_q <= burst_d;
      idle_q  <= idle_d;
      data_q  <= data_d;
      last_q  <= last_d;
    end
  assign req_ready_o   = (state_q == SEND && !tx_busy_i) ? N_REQ'(1) << gid_q : '0;
  assign tx_start_o    = state_q == LOAD;
  assign tx_data_o     = data_q;
  assign grant_valid_o = state_q != IDLE;
  assign grant_id_o    = gid_q;
endmodule

// File: tb/tb_uart_tx_arbiter.sv
// tb_uart_tx_arbiter: directed bench with client byte queues and a small UART frame model.
module tb_uart_tx_arbiter;
  localparam int N = 4;
  logic clk = 0, rst_n = 0;
  always #5 clk = ~clk;
  logic [N-1:0] req_valid, req_last, req_ready;
  logic [8*N-1:0] req_data;
  logic tx_busy, tx_done, tx_start, grant_valid;
  logic [7:0] tx_data;
  logic [1:0] grant_id;
  logic auto_m = 1, man_busy = 0, man_done = 0, m_busy, m_done;
  int m_cnt;
  logic [7:0] mem [N][64];
  logic mlast [N][64];
  int wr [N] = '{default: 0};
  int rd [N] = '{default: 0};
  int total = 0, bad = 0;
  int cyc = 0, done_cyc = 0, rel_cyc = 0;
  logic prev_gv = 0;
  logic [1:0] glog [$];
  logic [9:0] tlog [$];

  uart_tx_arbiter dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid_i(req_valid), .req_last_i(req_last), .req_data_i(req_data),
    .req_ready_o(req_ready), .tx_busy_i(tx_busy), .tx_done_i(tx_done),
    .tx_start_o(tx_start), .tx_data_o(tx_data),
    .grant_valid_o(grant_valid), .grant_id_o(grant_id)
  );

  always_comb
    for (int i = 0; i < N; i++) begin
      req_valid[i]       = rd[i] != wr[i];
      req_last[i]        = mlast[i][rd[i]];
      req_data[8*i +: 8] = mem[i][rd[i]];
    end
  always @(posedge clk)
    for (int i = 0; i < N; i++)
      if (req_valid[i] && req_ready[i]) rd[i] <= rd[i] + 1;

  // UART stand-in: busy for four cycles after a start, then a one-cycle done
  always @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      m_busy <= 0; m_done <= 0; m_cnt <= 0;
    end else begin
      m_done <= 0;
      if (m_cnt > 0) begin
        m_cnt <= m_cnt - 1;
        if (m_cnt == 1) begin m_busy <= 0; m_done <= 1; end
      end else if (tx_start && auto_m) begin
        m_busy <= 1; m_cnt <= 4;
      end
    end
  assign tx_busy = auto_m ? m_busy : man_busy;
  assign tx_done = auto_m ? m_done : man_done;

  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk) begin
    if (tx_start) tlog.push_back({grant_id, tx_data});
    if (grant_valid && !prev_gv) glog.push_back(grant_id);
    if (!grant_valid && prev_gv) rel_cyc = cyc;
    if (tx_done) done_cyc = cyc;
    prev_gv = grant_valid;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask
  task automatic nc();
    @(negedge clk); #1;
  endtask
  task automatic load(input int c, input logic [7:0] d, input logic l);
    mem[c][wr[c]] = d; mlast[c][wr[c]] = l; wr[c]++;
  endtask
  function automatic bit drained();
    for (int i = 0; i < N; i++) if (rd[i] != wr[i]) return 0;
    return 1;
  endfunction
  task automatic wait_idle(input int budget, input string tag);
    int n = 0;
    while ((grant_valid || !drained()) && n < budget) begin nc(); n++; end
    chk(tag, 32'(n < budget), 1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation ran past its time limit");
    $fatal(1);
  end

  initial begin
    int g0, t0, n;
    logic [7:0] e2 [3] = '{8'hA5, 8'h5A, 8'hFF};
    logic [1:0] eg3 [5] = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
    logic [7:0] ed3 [5] = '{8'h01, 8'h11, 8'h21, 8'h31, 8'h02};
    logic [1:0] eg4 [4] = '{2'd1, 2'd3, 2'd1, 2'd1};
    repeat (3) nc();
    chk("rst_gv", grant_valid, 0);
    chk("rst_start", tx_start, 0);
    chk("rst_ready", req_ready, 0);
    chk("rst_data", tx_data, 0);
    chk("rst_gid", grant_id, 0);
    rst_n = 1;
    nc();
    // single client, three bytes, with exact latency
    g0 = glog.size(); t0 = tlog.size();
    load(2, 8'hA5, 0); load(2, 8'h5A, 0); load(2, 8'hFF, 1);
    nc();
    chk("t2_gv", grant_valid, 1);
    chk("t2_gid", grant_id, 2);
    chk("t2_ready", req_ready, 4'b0100);
    nc();
    chk("t2_start", tx_start, 1);
    chk("t2_data0", tx_data, 8'hA5);
    chk("t2_ready_load", req_ready, 0);
    wait_idle(300, "t2_finish");
    nc();
    chk("t2_ntx", tlog.size() - t0, 3);
    for (int k = 0; k < 3; k++) chk("t2_tx", tlog[t0+k], {2'd2, e2[k]});
    chk("t2_ngnt", glog.size() - g0, 1);
    chk("t2_rel_after_done", rel_cyc - done_cyc, 1);
    // reset while waiting for tx_done
    load(2, 8'h3C, 1);
    n = 0;
    while (!tx_start && n < 20) begin nc(); n++; end
    chk("t1_load", tx_start, 1);
    nc();
    chk("t1_wait_gv", grant_valid, 1);
    rst_n = 0; auto_m = 0;
    #1;
    chk("t1_rst_gv", grant_valid, 0);
    chk("t1_rst_start", tx_start, 0);
    chk("t1_rst_ready", req_ready, 0);
    nc(); nc();
    rst_n = 1;
    nc();
    man_done = 1;
    nc();
    man_done = 0;
    chk("t1_done_ign_gv", grant_valid, 0);
    chk("t1_done_ign_start", tx_start, 0);
    auto_m = 1;
    g0 = glog.size();
    load(3, 8'h33, 1); load(0, 8'hC0, 1);
    nc();
    chk("t1_rr_gv", grant_valid, 1);
    chk("t1_rr_gid", grant_id, 0);
    wait_idle(300, "t1_finish");
    nc();
    chk("t1_ngnt", glog.size() - g0, 2);
    chk("t1_second", glog[g0+1], 3);
    // all clients at once, pointer wraps back to 0
    g0 = glog.size(); t0 = tlog.size();
    load(0, 8'h01, 1); load(1, 8'h11, 1); load(2, 8'h21, 1); load(3, 8'h31, 1); load(0, 8'h02, 1);
    wait_idle(500, "t3_finish");
    nc();
    chk("t3_ngnt", glog.size() - g0, 5);
    chk("t3_ntx", tlog.size() - t0, 5);
    for (int k = 0; k < 5; k++) begin
      chk("t3_gnt", glog[g0+k], eg3[k]);
      chk("t3_tx", tlog[t0+k], {eg3[k], ed3[k]});
    end
    // burst limit with a waiting client
    g0 = glog.size(); t0 = tlog.size();
    for (int k = 0; k < 20; k++) load(1, 8'h40 + 8'(k), 0);
    load(3, 8'h77, 1);
    wait_idle(3000, "t4_finish");
    nc();
    chk("t4_ngnt", glog.size() - g0, 4);
    for (int k = 0; k < 4; k++) chk("t4_gnt", glog[g0+k], eg4[k]);
    chk("t4_ntx", tlog.size() - t0, 21);
    for (int k = 0; k < 21; k++)
      chk("t4_tx", tlog[t0+k], k < 8 ? {2'd1, 8'h40 + 8'(k)} : k == 8 ? {2'd3, 8'h77} : {2'd1, 8'h40 + 8'(k - 1)});
    // idle timeout measured from SEND entry
    load(2, 8'h99, 0);
    n = 0;
    while (!tx_done && n < 50) begin nc(); n++; end
    chk("t5_done_seen", tx_done, 1);
    chk("t5_gid", grant_id, 2);
    n = 0;
    do begin nc(); n++; end while (grant_valid && n < 40);
    chk("t5_timeout_cycles", n, 17);
    // transmitter busy holds off the handshake
    auto_m = 0; man_busy = 1;
    load(0, 8'hC3, 1);
    nc();
    chk("t6_gv", grant_valid, 1);
    chk("t6_gid", grant_id, 0);
    for (int k = 0; k < 4; k++) begin
      chk("t6_busy_ready", req_ready, 0);
      chk("t6_busy_start", tx_start, 0);
      nc();
    end
    man_busy = 0;
    #1;
    chk("t6_ready", req_ready, 4'b0001);
    nc();
    chk("t6_start", tx_start, 1);
    chk("t6_data", tx_data, 8'hC3);
    nc();
    chk("t6_start_pulse", tx_start, 0);
    chk("t6_wait_gv", grant_valid, 1);
    man_done = 1;
    nc();
    man_done = 0;
    chk("t6_release", grant_valid, 0);
    auto_m = 1;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
